// File: rtl/divider_n.sv
// Iterative radix-2 restoring divider, signed or unsigned, with optional early-out.
// Divide-by-zero and signed overflow complete in one cycle with defined results.
module divider_n #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             flush_exception,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             div_by_zero,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    // Handshake: en is a request level sampled only in IDLE and held high until
    // ready; ready is a one-cycle valid for quotient, remainder and div_by_zero.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] start_dvd;
    logic [CW-1:0]    dvd_lz;
    logic [CW-1:0]    start_count;
    logic             is_zero_div;
    logic             is_overflow;
    logic             is_small;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] next_dvd;
    logic [WIDTH-1:0] next_rem;

    function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    always_comb begin
        dvd_abs     = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs     = (sign && divisor[WIDTH-1]) ? -divisor : divisor;
        dvd_lz      = EARLY_OUT ? lzc(dvd_abs) : '0;
        // Pre-aligning the dividend lets iteration start at its top set bit.
        start_count = (dvd_lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - dvd_lz;
        start_dvd   = dvd_abs << dvd_lz;
        is_zero_div = (divisor == '0);
        is_overflow = sign && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
        is_small    = EARLY_OUT && (dvd_abs < dvs_abs);
        // The shifted partial remainder is below twice the divisor, so the
        // difference's top bit is a clean borrow.
        shifted     = {rem_q, dvd_q[WIDTH-1]};
        diff        = shifted - {1'b0, dvs_q};
        qbit        = ~diff[WIDTH];
        next_rem    = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_dvd    = {dvd_q[WIDTH-2:0], qbit};
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else if (flush_exception) begin
            state <= IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        sign_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= sign & dividend[WIDTH-1];
                        busy   <= 1'b1;
                        if (is_zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            ready       <= 1'b1;
                            state       <= DONE;
                        end else if (is_overflow) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            ready       <= 1'b1;
                            state       <= DONE;
                        end else if (is_small) begin
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b0;
                            ready       <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd_q <= start_dvd;
                            dvs_q <= dvs_abs;
                            rem_q <= '0;
                            count <= start_count;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dvd_q <= next_dvd;
                        rem_q <= next_rem;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            quotient    <= sign_q ? -next_dvd : next_dvd;
                            remainder   <= sign_r ? -next_rem : next_rem;
                            div_by_zero <= 1'b0;
                            ready       <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_n.sv
// Bench for divider_n: directed cases plus randomized operations against an
// arithmetic reference, on a plain and an early-out instance.
module tb_divider_n;
    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        en_n, en_e;
    logic [31:0] q_n, r_n, q_e, r_e;
    logic        rdy_n, dbz_n, busy_n, rdy_e, dbz_e, busy_e;
    logic [1:0]  st_n, st_e;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    divider_n #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_n (
        .clk(clk), .rstn(rstn), .en(en_n), .flush_exception(flush), .sign(sign),
        .dividend(dividend), .divisor(divisor), .quotient(q_n), .remainder(r_n),
        .ready(rdy_n), .div_by_zero(dbz_n), .busy(busy_n), .state_dbg(st_n)
    );

    divider_n #(.WIDTH(32), .EARLY_OUT(1'b1)) dut_e (
        .clk(clk), .rstn(rstn), .en(en_e), .flush_exception(flush), .sign(sign),
        .dividend(dividend), .divisor(divisor), .quotient(q_e), .remainder(r_e),
        .ready(rdy_e), .div_by_zero(dbz_e), .busy(busy_e), .state_dbg(st_e)
    );

    // Reference: plain 64-bit arithmetic plus the special-case and latency rules.
    function automatic void model(input bit eo, input bit s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic dbz, output int lat);
        longint sa, sb, ma, mb;
        sa  = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = s ? longint'($signed(b)) : longint'({32'b0, b});
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        dbz = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; lat = 1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            if (!eo) lat = 33;
            else if (ma < mb) lat = 1;
            else lat = $clog2(ma + 1) + 1;
        end
    endfunction

    // Driver: start one operation, scramble operands after the start edge,
    // wait (bounded) for ready, then spend the mandatory DONE->IDLE cycle.
    task automatic run_op(input bit eo, input bit s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz,
                          output int lat, output bit busy_ok);
        q = 'x; r = 'x; dbz = 'x; lat = -1; busy_ok = 1'b1;
        sign = s; dividend = a; divisor = b;
        if (eo) en_e = 1'b1; else en_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                sign = 1'($urandom); dividend = $urandom; divisor = $urandom;
            end
            if ((eo ? busy_e : busy_n) !== 1'b1) busy_ok = 1'b0;
            if ((eo ? rdy_e : rdy_n) === 1'b1) begin
                lat = c;
                q   = eo ? q_e : q_n;
                r   = eo ? r_e : r_n;
                dbz = eo ? dbz_e : dbz_n;
                break;
            end
        end
        en_n = 1'b0; en_e = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (q_n !== 32'd0 || r_n !== 32'd0 || rdy_n !== 1'b0 || dbz_n !== 1'b0 || busy_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_n: q=%h r=%h rdy=%b dbz=%b busy=%b, expected all zero", q_n, r_n, rdy_n, dbz_n, busy_n);
        end
        checks++;
        if (q_e !== 32'd0 || r_e !== 32'd0 || rdy_e !== 1'b0 || dbz_e !== 1'b0 || busy_e !== 1'b0) begin
            fails++;
            $display("FAIL reset_e: q=%h r=%h rdy=%b dbz=%b busy=%b, expected all zero", q_e, r_e, rdy_e, dbz_e, busy_e);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; logic dbz; int lat; bit bok;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd14 || r !== 32'd2 || dbz !== 1'b0 || lat != 33 || !bok) begin
            fails++;
            $display("FAIL udiv_100_7: q=%h r=%h dbz=%b lat=%0d busy_ok=%0b, expected q=e r=2 dbz=0 lat=33 busy_ok=1", q, r, dbz, lat, bok);
        end
        checks++;
        if (busy_n !== 1'b0 || rdy_n !== 1'b0) begin
            fails++;
            $display("FAIL after_done: busy=%b rdy=%b, expected 0 0", busy_n, rdy_n);
        end
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'h7FFF_FFFC || r !== 32'd1 || lat != 33) begin
            fails++;
            $display("FAIL udiv_big: q=%h r=%h lat=%0d, expected q=7ffffffc r=1 lat=33", q, r, lat);
        end
    endtask

    task automatic test_signed();
        logic [31:0] q, r; logic dbz; int lat; bit bok;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || lat != 33) begin
            fails++;
            $display("FAIL sdiv_m7_2: q=%h r=%h lat=%0d, expected q=fffffffd r=ffffffff lat=33", q, r, lat);
        end
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'hFFFF_FFFD || r !== 32'd1 || lat != 33) begin
            fails++;
            $display("FAIL sdiv_7_m2: q=%h r=%h lat=%0d, expected q=fffffffd r=1 lat=33", q, r, lat);
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] q, r; logic dbz; int lat; bit bok;
        for (int s = 0; s < 2; s++) begin
            run_op(1'b0, 1'(s), 32'h1234_5678, 32'd0, q, r, dbz, lat, bok);
            checks++;
            if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678 || dbz !== 1'b1 || lat != 1 || !bok) begin
                fails++;
                $display("FAIL div_zero s=%0d: q=%h r=%h dbz=%b lat=%0d busy_ok=%0b, expected q=ffffffff r=12345678 dbz=1 lat=1 busy_ok=1", s, q, r, dbz, lat, bok);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r; logic dbz; int lat; bit bok;
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'h8000_0000 || r !== 32'd0 || dbz !== 1'b0 || lat != 1) begin
            fails++;
            $display("FAIL ovf_signed: q=%h r=%h dbz=%b lat=%0d, expected q=80000000 r=0 dbz=0 lat=1", q, r, dbz, lat);
        end
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd0 || r !== 32'h8000_0000 || lat != 33) begin
            fails++;
            $display("FAIL ovf_unsigned: q=%h r=%h lat=%0d, expected q=0 r=80000000 lat=33", q, r, lat);
        end
    endtask

    task automatic test_abort();
        logic [31:0] q, r; logic dbz; int lat; bit bok; bit seen;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, q, r, dbz, lat, bok);
        // Flush at cycle 10 of a division.
        sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; en_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; en_n = 1'b0;
        checks++;
        if (busy_n !== 1'b0 || rdy_n !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy: busy=%b rdy=%b, expected 0 0", busy_n, rdy_n);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (rdy_n === 1'b1) seen = 1'b1; end
        checks++;
        if (seen || q_n !== 32'd14 || r_n !== 32'd2 || dbz_n !== 1'b0) begin
            fails++;
            $display("FAIL flush_hold: ready_seen=%0b q=%h r=%h dbz=%b, expected 0 e 2 0", seen, q_n, r_n, dbz_n);
        end
        run_op(1'b0, 1'b0, 32'd9, 32'd3, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || lat != 33) begin
            fails++;
            $display("FAIL after_flush_9_3: q=%h r=%h lat=%0d, expected q=3 r=0 lat=33", q, r, lat);
        end
        // en dropped mid-CALC.
        sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; en_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        en_n = 1'b0;
        @(posedge clk); #1;
        seen = 1'b0;
        checks++;
        if (busy_n !== 1'b0) begin
            fails++;
            $display("FAIL en_drop_busy: busy=%b, expected 0", busy_n);
        end
        repeat (40) begin @(posedge clk); #1; if (rdy_n === 1'b1) seen = 1'b1; end
        checks++;
        if (seen || q_n !== 32'd3 || r_n !== 32'd0) begin
            fails++;
            $display("FAIL en_drop_hold: ready_seen=%0b q=%h r=%h, expected 0 3 0", seen, q_n, r_n);
        end
        run_op(1'b0, 1'b0, 32'd100, 32'd7, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd14 || r !== 32'd2 || lat != 33) begin
            fails++;
            $display("FAIL after_en_drop: q=%h r=%h lat=%0d, expected q=e r=2 lat=33", q, r, lat);
        end
        // Asynchronous reset mid-CALC, checked before the next clock edge.
        sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; en_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy_n !== 1'b0 || q_n !== 32'd0 || r_n !== 32'd0 || rdy_n !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: busy=%b q=%h r=%h rdy=%b, expected 0 0 0 0", busy_n, q_n, r_n, rdy_n);
        end
        #2;
        rstn = 1'b1; en_n = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (rdy_n === 1'b1) seen = 1'b1; end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL reset_no_ready: ready_seen=%0b, expected 0", seen);
        end
        run_op(1'b0, 1'b0, 32'd9, 32'd3, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || lat != 33) begin
            fails++;
            $display("FAIL after_reset_9_3: q=%h r=%h lat=%0d, expected q=3 r=0 lat=33", q, r, lat);
        end
    endtask

    task automatic test_flush_on_completion();
        bit seen;
        sign = 1'b0; dividend = 32'd100; divisor = 32'd7; en_n = 1'b1;
        @(posedge clk); #1;
        repeat (31) @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; en_n = 1'b0;
        seen = (rdy_n === 1'b1);
        repeat (5) begin @(posedge clk); #1; if (rdy_n === 1'b1) seen = 1'b1; end
        checks++;
        if (seen || busy_n !== 1'b0 || q_n !== 32'd3 || r_n !== 32'd0) begin
            fails++;
            $display("FAIL flush_at_last: ready_seen=%0b busy=%b q=%h r=%h, expected 0 0 3 0", seen, busy_n, q_n, r_n);
        end
    endtask

    task automatic test_early_out();
        logic [31:0] q, r; logic dbz; int lat; bit bok;
        run_op(1'b1, 1'b0, 32'd5, 32'd9, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd0 || r !== 32'd5 || lat != 1) begin
            fails++;
            $display("FAIL eo_5_9: q=%h r=%h lat=%0d, expected q=0 r=5 lat=1", q, r, lat);
        end
        run_op(1'b1, 1'b0, 32'hFF, 32'd3, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd85 || r !== 32'd0 || lat != 9 || !bok) begin
            fails++;
            $display("FAIL eo_ff_3: q=%h r=%h lat=%0d busy_ok=%0b, expected q=55 r=0 lat=9 busy_ok=1", q, r, lat, bok);
        end
        run_op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, q, r, dbz, lat, bok);
        checks++;
        if (q !== 32'd0 || r !== 32'hFFFF_FFFD || lat != 1) begin
            fails++;
            $display("FAIL eo_m3_7: q=%h r=%h lat=%0d, expected q=0 r=fffffffd lat=1", q, r, lat);
        end
    endtask

    task automatic test_random(input bit eo, input int n);
        logic [31:0] a, b, q, r, eq, er; logic dbz, edbz; int lat, elat; bit bok, s;
        for (int i = 0; i < n; i++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3:       begin a = $urandom; b = $urandom_range(1, 15); end
                4, 5:    begin a = $urandom >> $urandom_range(0, 31); b = $urandom >> $urandom_range(0, 31); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            model(eo, s, a, b, eq, er, edbz, elat);
            run_op(eo, s, a, b, q, r, dbz, lat, bok);
            checks++;
            if (q !== eq || r !== er || dbz !== edbz || lat != elat || !bok) begin
                fails++;
                $display("FAIL rand_%s #%0d: s=%0b a=%h b=%h got q=%h r=%h dbz=%b lat=%0d busy_ok=%0b, expected q=%h r=%h dbz=%b lat=%0d busy_ok=1",
                         eo ? "eo" : "n", i, s, a, b, q, r, dbz, lat, bok, eq, er, edbz, elat);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
        en_n = 1'b0; en_e = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_abort();
        test_flush_on_completion();
        test_early_out();
        test_random(1'b0, 200);
        test_random(1'b1, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
